// File: rtl/line_clear_unit.sv
// rtl/line_clear_unit.sv - Removes full rows from a stacked board, compacts it and keeps score (option: LINE_CLEAR_WEIGHTED_SCORE_EN)
module line_clear_unit #(
    parameter int ROWS    = 23,
    parameter int COLS    = 10,
    parameter int SCORE_W = 16
) (
    input  logic                 clk_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear_score,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_out,
    output logic                 board_we,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score
);

    localparam int BOARD_W = ROWS * COLS;
    localparam int PTR_W   = $clog2(ROWS);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [BOARD_W-1:0]  board_q;
    logic [PTR_W-1:0]    row_q;
    logic [4:0]          cnt_q;
    logic [4:0]          lines_q;
    logic [SCORE_W-1:0]  score_q;
    logic                board_we_q;
    logic                busy_q;
    logic                done_q;

    logic [COLS-1:0]     cur_row;
    logic                row_full;
    logic [BOARD_W-1:0]  board_shift_d;
    logic [SCORE_W:0]    inc_d;
    logic [SCORE_W:0]    sum_d;
    logic [SCORE_W-1:0]  score_d;
`ifdef LINE_CLEAR_WEIGHTED_SCORE_EN
    logic [3:0]          part_d;
`endif

    // Pick the row under the pointer and build the board with that row dropped out
    always_comb begin
        cur_row = '0;
        for (int j = 0; j < ROWS; j++) begin
            if (row_q == PTR_W'(j)) begin
                cur_row = board_q[j*COLS +: COLS];
            end
        end
        row_full = &cur_row;

        // Rows 1..pointer slide down by one, row 0 refills empty, rows below stay
        board_shift_d = board_q;
        board_shift_d[0 +: COLS] = '0;
        for (int j = 1; j < ROWS; j++) begin
            if (j <= int'(row_q)) begin
                board_shift_d[j*COLS +: COLS] = board_q[(j-1)*COLS +: COLS];
            end
        end
    end

    // Score increment for the finished piece, saturating at the register maximum
    always_comb begin
`ifdef LINE_CLEAR_WEIGHTED_SCORE_EN
        // Each complete group of four lines is worth 8, the remainder 0/1/3/5
        case (cnt_q[1:0])
            2'd0:    part_d = 4'd0;
            2'd1:    part_d = 4'd1;
            2'd2:    part_d = 4'd3;
            default: part_d = 4'd5;
        endcase
        inc_d = (SCORE_W+1)'({cnt_q[4:2], 3'b000}) + (SCORE_W+1)'(part_d);
`else
        inc_d = (SCORE_W+1)'(cnt_q);
`endif
        sum_d   = {1'b0, score_q} + inc_d;
        score_d = sum_d[SCORE_W] ? '1 : sum_d[SCORE_W-1:0];
    end

    // Control FSM with registered outputs; one row evaluated per SCAN cycle
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            board_q    <= '0;
            row_q      <= LAST_ROW;
            cnt_q      <= '0;
            lines_q    <= '0;
            score_q    <= '0;
            board_we_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            board_we_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        board_q <= board_in;
                        row_q   <= LAST_ROW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        // Pointer holds so the row shifted in gets examined next
                        board_q <= board_shift_d;
                        cnt_q   <= cnt_q + 5'd1;
                    end else if (row_q != '0) begin
                        row_q <= row_q - PTR_W'(1);
                    end else begin
                        // Outputs are registered, so they are set on entry to DONE
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        board_we_q <= 1'b1;
                        lines_q    <= cnt_q;
                        score_q    <= score_d;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // New-game clear overrides any score update on the same edge
            if (clear_score) begin
                score_q <= '0;
            end
        end
    end

    assign board_out     = board_q;
    assign board_we      = board_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign score         = score_q;

endmodule

// File: doc/line_clear_unit.md
Name: line_clear_unit

Overview:
- Downstream of the board state recorder: after a falling piece is stacked, it takes the 230-bit board, removes every full row, and drops the rows above into place.
- Returns the compacted board with a one-cycle write-back strobe to the recorder.
- Reports the number of lines cleared for this piece and keeps a running score.
- Multi-cycle FSM: scans one row per cycle, bottom row first.

Parameters:
- ROWS, 23, board height; row 0 is the top and row ROWS-1 is the bottom.
- COLS, 10, board width; column 0 is the left edge.
- SCORE_W, 16, width of the cumulative score register.

Ports:
- clk_50  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse meaning "piece just stacked, process board_in"; sampled only in IDLE.
- clear_score  input  1  synchronous clear of score (new game).
- board_in  input  ROWS*COLS  board to process; row r occupies bits [r*COLS +: COLS], and column c is bit r*COLS + (COLS-1-c).
- board_out  output  ROWS*COLS  working/compacted board; same packing as board_in.
- board_we  output  1  one-cycle strobe; the recorder loads board_out on this cycle.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  output  1  one-cycle pulse, coincident with board_we.
- lines_cleared  output  5  full rows removed for the last processed piece; valid from done and held until the next accepted start.
- score  output  SCORE_W  cumulative score.

Behaviour:
- Reset values (async, reset=1): state=IDLE, board_out=0, board_we=0, busy=0, done=0, lines_cleared=0, score=0, row pointer=ROWS-1.
- States: IDLE, SCAN, DONE.
- IDLE, start=1: at the edge, board_out <= board_in, row <= ROWS-1, line counter <= 0, next state SCAN.
- IDLE, start=0: hold all outputs.
- SCAN, one cycle per evaluation. The examined row r is the current board_out row at the row pointer.
  - If r is full (all COLS bits = 1): every row j from 1 to the pointer takes row j-1; row 0 becomes all zeros; rows below the pointer are unchanged; line counter +1; the pointer stays put so the shifted-in row is re-examined next cycle.
  - If r is not full and pointer > 0: pointer decrements.
  - If r is not full and pointer = 0: next state DONE.
- DONE, single cycle:
  - done=1, board_we=1, busy=1, lines_cleared <= line counter.
  - score <= score + increment (see Optional Feature); saturates at 2^SCORE_W-1, no wrap.
  - Next state IDLE.
- Latency: with k full rows, DONE is the (ROWS+k+1)-th cycle after the start edge. k=0 gives 24 cycles; k=4 gives 28.
- Boundary and simultaneous-event rules:
  - A full row 0 is cleared and replaced with zeros; the scan then ends normally.
  - An empty board takes the k=0 path: done after 24 cycles with board unchanged.
  - start while busy is ignored; no queuing.
  - board_in is sampled only on the accepting edge; later changes have no effect.
  - clear_score in the same cycle as a DONE update: clear wins, score=0.
  - clear_score is honoured in any state.
  - reset mid-SCAN: immediate return to IDLE with reset values; board_we is not asserted, so the recorder keeps its previous board.
- board_out must not feed the recorder except under board_we.

Optional Feature:
- Macro: LINE_CLEAR_WEIGHTED_SCORE_EN.
- Defined: the DONE increment is weighted by lines_cleared: 0->0, 1->1, 2->3, 3->5, 4->8, >=5->8 per additional group; in practice 4 is the maximum per piece.
- Undefined: the increment equals lines_cleared, so score is total lines.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then start with board_in=0 -> done and board_we on cycle 24 after start; board_out=0; lines_cleared=0; score=0.
- Row 22 full and row 21 = column 0 only -> done on cycle 25; lines_cleared=1; row 22 of board_out = column 0 only; row 0 all zeros; score=1.
- Rows 19-22 full and row 18 = columns 3,4 -> lines_cleared=4; row 22 = columns 3,4; rows 19-21 empty; score=4 (8 with LINE_CLEAR_WEIGHTED_SCORE_EN); done on cycle 28.
- Rows 20 and 22 full, row 21 = column 5 -> non-adjacent clears; row 22 = column 5; lines_cleared=2; score 2 (3 weighted).
- Second start pulse on cycle 5 while busy -> ignored; single done; clear_score asserted on the DONE cycle -> score=0.
- Assert reset on cycle 10 of SCAN -> all outputs 0 asynchronously; no board_we pulse; a subsequent start completes normally.
